glb_rd_streamer: RTL and testbench

//   Read-side DMA for the global buffer (GLB). Given a bank, base address and word count,
//   it issues sequential GLB reads, absorbs the fixed GLB read latency, and presents the

---
 rtl/eyeriss_pkg.sv | 18 +
 rtl/glb_stream_fifo.sv | 61 ++++++
 rtl/glb_rd_streamer.sv | 136 +++++++++++++
 tb/tb_glb_rd_streamer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/eyeriss_pkg.sv
// Shared types for the GLB read streamer: bank codes and streamer FSM states.
package eyeriss_pkg;

    typedef enum logic [1:0] {
        BankNone  = 2'd0,
        BankIfmap = 2'd1,
        BankWght  = 2'd2,
        BankPsum  = 2'd3
    } glb_bank_e;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StDrain,
        StDone
    } rd_state_e;

endpackage

// File: rtl/glb_stream_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible while not empty.
module glb_stream_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4,
    parameter int unsigned CNT_W      = $clog2(DEPTH + 1)
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_empty,
    output logic [CNT_W-1:0]      o_count
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0] LastIdx = PtrW'(DEPTH - 1);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]      count_q;
    logic                  do_push, do_pop, full;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign o_empty = (count_q == '0);
    assign do_push = i_push && !full;
    assign do_pop  = i_pop && !o_empty;
    assign o_count = count_q;
    // Head is forced to zero when empty so stale storage never shows on the stream.
    assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q];

    // Storage array; contents need no reset because the empty flag masks them.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= i_data;
        end
    end

    // Pointers and occupancy; push and pop together leave the count unchanged.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= (wr_ptr_q == LastIdx) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= (rd_ptr_q == LastIdx) ? '0 : rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/glb_rd_streamer.sv
// Read-side GLB DMA: issues sequential reads under a credit limit, tracks the fixed
// read latency with a flag pipe and streams the returned words out through a FIFO.
module glb_rd_streamer
    import eyeriss_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned RD_LATENCY = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [1:0]            i_bank_sel,
    input  logic [ADDR_WIDTH-1:0] i_base_addr,
    input  logic [ADDR_WIDTH:0]   i_len,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [1:0]            o_glb_bank_sel,
    output logic                  o_glb_we,
    output logic [ADDR_WIDTH-1:0] o_glb_addr,
    input  logic [DATA_WIDTH-1:0] i_glb_rd,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready
);

    localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned LenW = ADDR_WIDTH + 1;
    localparam logic [CntW:0] Credits = (CntW + 1)'(FIFO_DEPTH);

    rd_state_e             state_q, state_d;
    glb_bank_e             bank_q, bank_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [LenW-1:0]       remaining_q, remaining_d;
    logic [RD_LATENCY-1:0] pipe_q;
    logic                  issue, push, pop, fifo_empty, credit_ok;
    logic [CntW-1:0]       fifo_count, inflight;

    // Credit: words in flight plus words buffered must leave room in the FIFO.
    always_comb begin
        inflight = '0;
        for (int i = 0; i < int'(RD_LATENCY); i++) begin
            inflight = inflight + CntW'(pipe_q[i]);
        end
        credit_ok = ({1'b0, inflight} + {1'b0, fifo_count}) < Credits;
    end

    // Next-state logic: job latch, address walk and issue decisions.
    always_comb begin
        state_d     = state_q;
        bank_d      = bank_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        issue       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    bank_d      = glb_bank_e'(i_bank_sel);
                    remaining_d = i_len;
                    if (i_len == '0) begin
                        state_d = StDone;
                    end else begin
                        addr_d  = i_base_addr;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    remaining_d = remaining_q - LenW'(1);
                    // Hold the final address so the bus stops at the last word read.
                    if (remaining_q == LenW'(1)) begin
                        state_d = StDrain;
                    end else begin
                        addr_d = addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            StDrain: begin
                if (pipe_q == '0 && fifo_empty) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, job registers and in-flight flag pipe.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= StIdle;
            bank_q      <= BankNone;
            addr_q      <= '0;
            remaining_q <= '0;
            pipe_q      <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            pipe_q      <= (pipe_q << 1) | RD_LATENCY'(issue);
        end
    end

    assign push = pipe_q[RD_LATENCY-1];
    assign pop  = o_valid && i_ready;

    glb_stream_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (FIFO_DEPTH),
        .CNT_W      (CntW)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (push),
        .i_data  (i_glb_rd),
        .i_pop   (pop),
        .o_data  (o_data),
        .o_empty (fifo_empty),
        .o_count (fifo_count)
    );

    // Bank select stays on the job bank through DRAIN so every capture sees it.
    assign o_busy         = (state_q == StIssue) || (state_q == StDrain);
    assign o_done         = (state_q == StDone);
    assign o_glb_bank_sel = o_busy ? bank_q : 2'd0;
    assign o_glb_we       = 1'b0;
    assign o_glb_addr     = addr_q;
    assign o_valid        = !fifo_empty;

endmodule

// File: tb/tb_glb_rd_streamer.sv
// Directed-random bench for glb_rd_streamer with a latency-2 GLB model.
module tb_glb_rd_streamer;

    localparam int AW = 13;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          i_rst, i_start, i_ready;
    logic [1:0]    i_bank_sel;
    logic [AW-1:0] i_base_addr;
    logic [AW:0]   i_len;
    logic          o_busy, o_done, o_glb_we, o_valid;
    logic [1:0]    o_glb_bank_sel;
    logic [AW-1:0] o_glb_addr;
    logic [DW-1:0] i_glb_rd, o_data;

    glb_rd_streamer dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_start        (i_start),
        .i_bank_sel     (i_bank_sel),
        .i_base_addr    (i_base_addr),
        .i_len          (i_len),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_glb_bank_sel (o_glb_bank_sel),
        .o_glb_we       (o_glb_we),
        .o_glb_addr     (o_glb_addr),
        .i_glb_rd       (i_glb_rd),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready)
    );

    always #5 clk = ~clk;

    // Bank 1 holds mem[a]=a; other banks tag the upper byte so a wrong bank is visible.
    function automatic logic [DW-1:0] glb_word(input logic [1:0] b, input logic [AW-1:0] a);
        if (b == 2'd0) return '0;
        return ((32'(b) - 32'd1) << 24) | 32'(a);
    endfunction

    // GLB: registered RAM, two-cycle latency, combinational bank mux on the output.
    logic [AW-1:0] a1, a2;
    always @(posedge clk) begin
        a1 <= o_glb_addr;
        a2 <= a1;
    end
    assign i_glb_rd = glb_word(o_glb_bank_sel, a2);

    int            cyc = 0;
    int            n_cmp = 0, n_fail = 0;
    bit            rand_rdy = 1'b0;
    logic [1:0]    exp_bank = 2'd0;
    logic [DW-1:0] rx_q[$], exp_q[$];
    logic [AW-1:0] addr_trace[$];
    logic [AW-1:0] prev_addr = '0;
    int first_valid, last_rx, done_cnt, done_cyc, valid_cnt, bank_bad, addr_changes;
    bit busy_at_done;

    always @(posedge clk) cyc++;

    // Passive monitor sampled on the falling edge.
    always @(negedge clk) begin
        if (o_valid && i_ready) begin
            rx_q.push_back(o_data);
            if (first_valid < 0) first_valid = cyc;
            last_rx = cyc;
        end
        if (o_valid) valid_cnt++;
        if (o_done) begin
            done_cnt++;
            done_cyc     = cyc;
            busy_at_done = o_busy;
        end
        if (o_busy ? (o_glb_bank_sel != exp_bank) : (o_glb_bank_sel != 2'd0)) bank_bad++;
        if (o_glb_addr != prev_addr) begin
            addr_changes++;
            prev_addr = o_glb_addr;
        end
        if (o_busy && (addr_trace.size() == 0 || o_glb_addr != addr_trace[$]))
            addr_trace.push_back(o_glb_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_rdy) i_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic clear_mon();
        rx_q.delete();
        exp_q.delete();
        addr_trace.delete();
        first_valid  = -1;
        last_rx      = -1;
        done_cnt     = 0;
        done_cyc     = -1;
        valid_cnt    = 0;
        bank_bad     = 0;
        addr_changes = 0;
        busy_at_done = 1'b0;
        prev_addr    = o_glb_addr;
    endtask

    task automatic start_job(input logic [1:0] b, input int base, input int len, output int t);
        clear_mon();
        exp_bank = b;
        for (int k = 0; k < len; k++) exp_q.push_back(glb_word(b, AW'((base + k) % 8192)));
        i_bank_sel  = b;
        i_base_addr = AW'(base);
        i_len       = (AW + 1)'(len);
        i_start     = 1'b1;
        t           = cyc;
        tick();
        i_start     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cyc);
        for (int i = 0; i < max_cyc && done_cnt == 0; i++) tick();
        check({tag, "_done_seen"}, 64'(done_cnt != 0), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        check({tag, "_done_once"}, 64'(done_cnt), 64'd1);
        check({tag, "_busy_at_done"}, 64'(busy_at_done), 64'd0);
        check({tag, "_bank_stable"}, 64'(bank_bad), 64'd0);
    endtask

    task automatic check_stream(input string tag);
        check({tag, "_count"}, 64'(rx_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < rx_q.size(); i++)
            check($sformatf("%s_word%0d", tag, i), 64'(rx_q[i]), 64'(exp_q[i]));
    endtask

    initial begin
        int t, base;
        i_rst = 1'b1; i_start = 1'b0; i_ready = 1'b1;
        i_bank_sel = '0; i_base_addr = '0; i_len = '0;
        clear_mon();
        tick(); tick(); tick();
        check("reset_outputs",
              {o_busy, o_done, o_valid, o_glb_we, o_glb_bank_sel, o_glb_addr, o_data}, '0);
        i_rst = 1'b0;
        tick();

        // 1: basic job, full rate.
        start_job(2'd1, 10, 8, t);
        check("basic_busy_t1", 64'(o_busy), 64'd1);
        check("basic_addr_t1", 64'(o_glb_addr), 64'd10);
        wait_done("basic", 60);
        check("basic_first_valid", 64'(first_valid - t), 64'd4);
        check("basic_back_to_back", 64'(last_rx - first_valid), 64'd7);
        check_stream("basic");

        // 2: random backpressure.
        rand_rdy = 1'b1;
        base = int'($urandom_range(0, 8000));
        start_job(2'd1, base, 16, t);
        wait_done("bp", 400);
        check_stream("bp");
        rand_rdy = 1'b0;
        i_ready  = 1'b1;

        // 3: address wrap past the top of the bank.
        start_job(2'd1, 8190, 4, t);
        wait_done("wrap", 60);
        check("wrap_trace_len", 64'(addr_trace.size()), 64'd4);
        if (addr_trace.size() == 4) begin
            check("wrap_addr0", 64'(addr_trace[0]), 64'd8190);
            check("wrap_addr1", 64'(addr_trace[1]), 64'd8191);
            check("wrap_addr2", 64'(addr_trace[2]), 64'd0);
            check("wrap_addr3", 64'(addr_trace[3]), 64'd1);
        end
        check_stream("wrap");

        // 4: zero-length job.
        start_job(2'd2, 100, 0, t);
        wait_done("len0", 10);
        check("len0_done_cycle", 64'(done_cyc - t), 64'd1);
        check("len0_addr_static", 64'(addr_changes), 64'd0);
        check("len0_no_valid", 64'(valid_cnt), 64'd0);

        // 5: reset in the middle of a job, then a clean job.
        start_job(2'd1, int'($urandom_range(0, 8191)), 16, t);
        for (int i = 0; i < 60 && rx_q.size() < 3; i++) tick();
        check("midrst_got3", 64'(rx_q.size() >= 3), 64'd1);
        i_rst = 1'b1;
        tick();
        check("midrst_outputs",
              {o_busy, o_done, o_valid, o_glb_we, o_glb_bank_sel, o_glb_addr, o_data}, '0);
        i_rst = 1'b0;
        clear_mon();
        for (int i = 0; i < 10; i++) tick();
        check("midrst_no_done", 64'(done_cnt), 64'd0);
        check("midrst_no_valid", 64'(valid_cnt), 64'd0);
        start_job(2'd2, int'($urandom_range(0, 8191)), 5, t);
        wait_done("postrst", 60);
        check_stream("postrst");

        // 6: start while busy is ignored; then a job on another bank.
        base = int'($urandom_range(0, 8191));
        start_job(2'd2, base, 6, t);
        tick();
        i_bank_sel  = 2'd3;
        i_base_addr = AW'(base + 50);
        i_len       = 14'd3;
        i_start     = 1'b1;
        tick();
        i_start     = 1'b0;
        wait_done("busy_start", 80);
        check_stream("busy_start");
        rand_rdy = 1'b1;
        start_job(2'd3, int'($urandom_range(0, 8191)), 6, t);
        wait_done("bank3", 200);
        check_stream("bank3");
        rand_rdy = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
